reg_file_wb: RTL and testbench

- MIPS general-purpose register file: 32 x 32-bit, two combinational read ports, one synchronous write port.
- Consumes the 5-bit destination register number produced by the write-register select (rt/rd choice) in the write-back stage.
- Decodes that number to a one-hot write enable and updates the selected register on the clock edge.
- Supplies rs/rt operands to the decode stage.

---
 rtl/mips_pkg.sv | 14 +
 rtl/reg_wr_decoder.sv | 20 ++
 rtl/reg_file_wb.sv | 71 +++++++
 tb/tb_reg_file_wb.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants: register address/word widths and the $zero index.
// Imported by the register file and its write decoder.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int WORD_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0]     word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_wr_decoder.sv
// Write-register decoder: address + enable -> one-hot register write strobe, $zero never enabled.
// Latency: combinational. Backpressure: none.
// No state; a deasserted enable yields an all-zero strobe whatever the address.
module reg_wr_decoder #(
  parameter int ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   en,
  output logic [(1<<ADDR_W)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
    onehot[0] = 1'b0;
  end

endmodule

// File: rtl/reg_file_wb.sv
// MIPS GPR file: 2**ADDR_W x DATA_W, two combinational read ports, one clocked write port.
// Latency: reads 0 cycles, writes visible after the edge. Backpressure: none (always accepts).
// Optional REGFILE_WB_BYPASS_EN forwards the in-flight write-back data onto matching read ports.
module reg_file_wb
  import mips_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]   wr_en;
  logic [DATA_W-1:0] regs [NREG];

  reg_wr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_wr_dec (
    .addr   (write_reg),
    .en     (reg_write),
    .onehot (wr_en)
  );

  // Entry 0 is never strobed, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (wr_en[k]) begin
          regs[k] <= write_data;
        end
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  logic wb_live;
  // Reset squashes the write, so it must squash the forward as well.
  assign wb_live = reg_write && !reset && (write_reg != ADDR_W'(REG_ZERO));

  always_comb begin
    read_data1 = regs[read_reg1];
    read_data2 = regs[read_reg2];
    if (wb_live && (write_reg == read_reg1)) begin
      read_data1 = write_data;
    end
    if (wb_live && (write_reg == read_reg2)) begin
      read_data2 = write_data;
    end
  end
`else
  always_comb begin
    read_data1 = regs[read_reg1];
    read_data2 = regs[read_reg2];
  end
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: stimulus pushes expected read data, a negedge monitor pops and compares.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  reg_file_wb dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp1;
    logic [31:0] exp2;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic chk_vld = 1'b0;
  int   tests   = 0;
  int   fails   = 0;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Monitor: the DUT output is "presented" whenever the stimulus raises chk_vld.
  always @(negedge clk) begin
    if (chk_vld) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL no_expectation: monitor saw a read with an empty scoreboard");
      end else begin
        e = exp_q.pop_front();
        tests++;
        if (read_data1 !== e.exp1) begin
          fails++;
          $display("FAIL %s port1: got %h expected %h", e.name, read_data1, e.exp1);
        end
        tests++;
        if (read_data2 !== e.exp2) begin
          fails++;
          $display("FAIL %s port2: got %h expected %h", e.name, read_data2, e.exp2);
        end
      end
    end
  end

  // Present reads, queue their expected data, and hold until the monitor's negedge.
  task automatic chk(input logic [4:0] r1, input logic [4:0] r2,
                     input logic [31:0] e1, input logic [31:0] e2, input string name);
    exp_t e;
    read_reg1 = r1;
    read_reg2 = r2;
    e.exp1 = e1;
    e.exp2 = e2;
    e.name = name;
    exp_q.push_back(e);
    chk_vld = 1'b1;
    @(negedge clk);
    #1 chk_vld = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_write  = 1'b1;
    write_reg  = a;
    write_data = d;
    @(posedge clk);
    #1 reg_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected < 200000", $time);
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    read_reg1  = '0;
    read_reg2  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk(5'd0, 5'd31, 32'h0, 32'h0, "reset_state");
    wr(5'd7, 32'hCAFE_F00D);  // ignored while reset is high
    chk(5'd7, 5'd7, 32'h0, 32'h0, "write_during_reset");

    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset clears immediately, before the next rising edge.
    wr(5'd5, 32'hDEAD_BEEF);
    chk(5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0, "load_r5");
    @(posedge clk);
    #1 reset = 1'b1;
    chk(5'd5, 5'd5, 32'h0, 32'h0, "async_reset_r5");
    for (int k = 0; k < 16; k++) begin
      chk(5'(k), 5'(k + 16), 32'h0, 32'h0, "reset_all");
    end
    @(posedge clk);
    #1 reset = 1'b0;

    wr(5'd17, 32'h1234_5678);
    chk(5'd17, 5'd16, 32'h1234_5678, 32'h0, "basic_r17_r16");
    chk(5'd18, 5'd17, 32'h0, 32'h1234_5678, "basic_r18_r17");

    // $zero: probed while the write is pending and after it commits.
    @(posedge clk);
    #1;
    reg_write  = 1'b1;
    write_reg  = 5'd0;
    write_data = 32'hFFFF_FFFF;
    chk(5'd0, 5'd0, 32'h0, 32'h0, "zero_same_cycle");
    @(posedge clk);
    #1 reg_write = 1'b0;
    chk(5'd0, 5'd0, 32'h0, 32'h0, "zero_after_edge");

    wr(5'd9, 32'h0000_0042);
    reg_write  = 1'b0;
    write_reg  = 5'd9;
    write_data = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    chk(5'd9, 5'd9, 32'h0000_0042, 32'h0000_0042, "we_gating");

    wr(5'd3, 32'h11);
    @(posedge clk);
    #1;
    reg_write  = 1'b1;
    write_reg  = 5'd3;
    write_data = 32'h22;
    chk(5'd17, 5'd3, 32'h1234_5678, BYPASS ? 32'h22 : 32'h11, "same_cycle_rw");
    @(posedge clk);
    #1 reg_write = 1'b0;
    chk(5'd3, 5'd3, 32'h22, 32'h22, "after_rw_edge");

    // Reset arriving together with a write wins.
    @(posedge clk);
    #1;
    reg_write  = 1'b1;
    write_reg  = 5'd20;
    write_data = 32'h77;
    reset      = 1'b1;
    chk(5'd20, 5'd3, 32'h0, 32'h0, "reset_vs_write_during");
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    reset     = 1'b0;
    chk(5'd20, 5'd3, 32'h0, 32'h0, "reset_vs_write_after");

    for (int k = 1; k < 32; k++) begin
      wr(5'(k), k * 32'h0101_0101);
    end
    for (int k = 1; k < 32; k++) begin
      chk(5'(k), 5'(31 - k), k * 32'h0101_0101, (31 - k) * 32'h0101_0101, "sweep");
    end
    chk(5'd12, 5'd12, 32'h0C0C_0C0C, 32'h0C0C_0C0C, "dual_port_r12");

    reg_write  = 1'b0;
    write_reg  = 'x;
    write_data = 'x;
    @(posedge clk);
    #1;
    chk(5'd12, 5'd1, 32'h0C0C_0C0C, 32'h0101_0101, "we_gating_x");

    @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
